// File: rtl/raster_pixel_scheduler.sv
// raster_pixel_scheduler
//
// Walks raster coordinates (x,y) into a shared fixed-latency pixel shader and
// streams the returned pixels out as AXI4-Stream video. Coordinates are
// issued against credits, one per output-buffer entry. A pixel can only be
// issued when it is certain to find room in the buffer, so the shader never
// has to stall and no pixel is lost while the sink applies backpressure.
//
// Ports:
//   aclk, aresetn        clock; synchronous active-low reset
//   start                pulse; begins a frame when idle
//   continuous           level; sampled at frame end to chain another frame
//   busy                 high from accepted start until the final frame completes
//   frame_done           one-cycle pulse on the handshake of the frame's last pixel
//   shd_x, shd_y         coordinate to the shader
//   shd_valid            coordinate issue strobe
//   shd_pixel            shader result, SHADER_LAT cycles after its shd_valid
//   m_axis_tdata/tvalid/tready/tlast/tuser
//                        AXIS video out; tuser = start of frame, tlast = end of line
module raster_pixel_scheduler #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 20,
  parameter int COORD_W    = 5,
  parameter int SHADER_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic               frame_done,
  output logic [COORD_W-1:0] shd_x,
  output logic [COORD_W-1:0] shd_y,
  output logic               shd_valid,
  input  logic [31:0]        shd_pixel,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               m_axis_tuser
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0]      CREDIT_MAX  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]      CREDIT_LAST = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]      CREDIT_ONE  = CW'(1);
  localparam logic [COORD_W-1:0] X_LAST      = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST      = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] COORD_ONE   = COORD_W'(1);
  localparam logic [AW-1:0]      PTR_ONE     = AW'(1);
  localparam logic [AW:0]        CNT_ONE     = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] x_q, y_q;
  logic [CW-1:0]      credits_q;

  logic issue;      // a coordinate goes to the shader this cycle
  logic frame_end;  // last pixel of the frame is being accepted
  logic restart;    // a new frame begins next cycle at (0,0)
  logic hs;         // AXIS handshake

  // Tracking pipeline, aligned with the shader: stage SHADER_LAT-1 describes
  // the pixel that is on shd_pixel in the current cycle.
  logic [SHADER_LAT-1:0] trk_vld_p;
  logic [SHADER_LAT-1:0] trk_sof_p;
  logic [SHADER_LAT-1:0] trk_eol_p;

  // Output buffer: {sof, eol, pixel}
  logic [33:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt_q;
  logic          fifo_wr;
  logic [33:0]   fifo_head;

  assign hs = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    frame_end = 1'b0;
    restart   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          restart = 1'b1;
        end
      end
      ISSUE: begin
        if (credits_q != '0) begin
          issue = 1'b1;
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Nothing is issued here, so the frame is complete when the handshake
        // returns the only credit still outstanding.
        if (hs && credits_q == CREDIT_LAST) begin
          frame_end = 1'b1;
          if (continuous) begin
            state_d = ISSUE;
            restart = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_end;
  assign shd_valid  = issue;
  assign shd_x      = x_q;
  assign shd_y      = y_q;

  // Raster coordinate counters with explicit wrap at the frame edges
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (restart) begin
      x_q <= '0;
      y_q <= '0;
    end else if (issue) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + COORD_ONE;
      end else begin
        x_q <= x_q + COORD_ONE;
      end
    end
  end

  // Credits = FIFO_DEPTH - (in flight + buffered)
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      credits_q <= CREDIT_MAX;
    end else begin
      case ({issue, hs})
        2'b10:   credits_q <= credits_q - CREDIT_ONE;
        2'b01:   credits_q <= credits_q + CREDIT_ONE;
        default: credits_q <= credits_q;
      endcase
    end
  end

  // ---- stage p0 .. p(SHADER_LAT-1): issue tags travel with the shader ----
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      trk_vld_p <= '0;
    end else begin
      trk_vld_p[0] <= issue;
      for (int i = 1; i < SHADER_LAT; i++) begin
        trk_vld_p[i] <= trk_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge aclk) begin
    trk_sof_p[0] <= (x_q == '0) && (y_q == '0);
    trk_eol_p[0] <= (x_q == X_LAST);
    for (int i = 1; i < SHADER_LAT; i++) begin
      trk_sof_p[i] <= trk_sof_p[i-1];
      trk_eol_p[i] <= trk_eol_p[i-1];
    end
  end

  // ---- pipeline output: shader result captured into the buffer ----
  assign fifo_wr = trk_vld_p[SHADER_LAT-1];

  always_ff @(posedge aclk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= {trk_sof_p[SHADER_LAT-1], trk_eol_p[SHADER_LAT-1], shd_pixel};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (hs) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({fifo_wr, hs})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // ---- AXIS output: head entry, forced to zero while the buffer is empty ----
  assign fifo_head     = fifo_mem[rd_ptr_q];
  assign m_axis_tvalid = (fifo_cnt_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_head[31:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & fifo_head[32];
  assign m_axis_tuser  = m_axis_tvalid & fifo_head[33];

endmodule

// File: tb/tb_raster_pixel_scheduler.sv
module tb_raster_pixel_scheduler;

  localparam int W     = 20;
  localparam int H     = 20;
  localparam int CWID  = 5;
  localparam int L     = 2;
  localparam int D     = 4;
  localparam int FRAME = W * H;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            start;
  logic            continuous;
  logic            busy;
  logic            frame_done;
  logic [CWID-1:0] shd_x;
  logic [CWID-1:0] shd_y;
  logic            shd_valid;
  logic [31:0]     shd_pixel;
  logic [31:0]     m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            m_axis_tuser;

  raster_pixel_scheduler #(
    .WIDTH(W), .HEIGHT(H), .COORD_W(CWID), .SHADER_LAT(L), .FIFO_DEPTH(D)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done),
    .shd_x(shd_x), .shd_y(shd_y), .shd_valid(shd_valid), .shd_pixel(shd_pixel),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser)
  );

  always #5 aclk = ~aclk;

  // Reference shader: pure function of the coordinate, delayed L cycles
  function automatic logic [31:0] shade(input logic [CWID-1:0] x, input logic [CWID-1:0] y);
    return {8'hC3, 3'b000, y, 3'b000, x, 8'h5A};
  endfunction

  logic [31:0] sh_p [L];
  always @(posedge aclk) begin
    sh_p[0] <= shade(shd_x, shd_y);
    for (int i = 1; i < L; i++) sh_p[i] <= sh_p[i-1];
  end
  assign shd_pixel = sh_p[L-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: ready, 1: stalled, 2: random
  int beat_idx, iss_idx, issue_cnt, fd_cnt, tuser_cnt, tlast_cnt, outstanding;
  int max_gap, last_hs_cyc, first_hs_cyc, t_start;
  bit          hold_q;
  logic [31:0] hold_data;
  logic        hold_last, hold_user;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    beat_idx = 0; iss_idx = 0; issue_cnt = 0; fd_cnt = 0; tuser_cnt = 0; tlast_cnt = 0;
    outstanding = 0; max_gap = 0; last_hs_cyc = 0; first_hs_cyc = 0; hold_q = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    chk({tag, "_svld"},  32'(shd_valid), 32'd0);
    chk({tag, "_sx"},    32'(shd_x), 32'd0);
    chk({tag, "_sy"},    32'(shd_y), 32'd0);
    chk({tag, "_tvld"},  32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"}, m_axis_tdata, 32'd0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    chk({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
  endtask

  // One clock cycle: drive tready, then observe and score this cycle
  task automatic tick();
    logic hs;
    @(posedge aclk);
    cyc++;
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'b0;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    hs = m_axis_tvalid && m_axis_tready;
    if (hold_q) begin
      chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("hold_tdata", m_axis_tdata, hold_data);
      chk("hold_tlast", 32'(m_axis_tlast), 32'(hold_last));
      chk("hold_tuser", 32'(m_axis_tuser), 32'(hold_user));
    end
    if (shd_valid) begin
      chk("issue_x", 32'(shd_x), 32'(iss_idx % W));
      chk("issue_y", 32'(shd_y), 32'((iss_idx / W) % H));
      iss_idx++;
      issue_cnt++;
    end
    if (hs || frame_done)
      chk("frame_done", 32'(frame_done), 32'(hs && (beat_idx % FRAME == FRAME - 1)));
    if (hs) begin
      chk("tdata", m_axis_tdata,
          shade(CWID'(beat_idx % W), CWID'((beat_idx / W) % H)));
      chk("tuser", 32'(m_axis_tuser), 32'(beat_idx % FRAME == 0));
      chk("tlast", 32'(m_axis_tlast), 32'(beat_idx % W == W - 1));
      if (m_axis_tuser) tuser_cnt++;
      if (m_axis_tlast) tlast_cnt++;
      if (beat_idx == 0) first_hs_cyc = cyc;
      else if (cyc - last_hs_cyc > max_gap) max_gap = cyc - last_hs_cyc;
      last_hs_cyc = cyc;
      beat_idx++;
    end
    if (frame_done) fd_cnt++;
    outstanding += int'(shd_valid) - int'(hs);
    if (shd_valid)
      chk("occupancy_bound", 32'(outstanding <= D && outstanding >= 0), 32'd1);
    hold_q    = m_axis_tvalid && !m_axis_tready;
    hold_data = m_axis_tdata;
    hold_last = m_axis_tlast;
    hold_user = m_axis_tuser;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (beat_idx < target && n < budget) begin
      tick();
      n++;
    end
    chk("beats_delivered", 32'(beat_idx), 32'(target));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("returns_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    aresetn = 1'b0; start = 1'b0; continuous = 1'b0; m_axis_tready = 1'b0;
    rdy_mode = 1;
    clr();

    // Reset state
    repeat (3) @(posedge aclk);
    #2;
    check_zero("reset");
    aresetn = 1'b1;
    tick();
    check_zero("after_reset");

    // Single frame, tready=1
    rdy_mode = 0;
    clr();
    do_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    run_until(FRAME, 1000);
    chk("first_beat_latency", 32'(first_hs_cyc - t_start), 32'(L + 1));
    chk("frame_throughput", 32'(last_hs_cyc - t_start), 32'(L + 1 + FRAME - 1));
    chk("t1_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("t1_tuser_cnt", 32'(tuser_cnt), 32'd1);
    chk("t1_tlast_cnt", 32'(tlast_cnt), 32'(H));
    tick();
    chk("t1_busy_low_next", 32'(busy), 32'd0);
    chk("t1_tvalid_low", 32'(m_axis_tvalid), 32'd0);
    chk("t1_issue_cnt", 32'(issue_cnt), 32'(FRAME));

    // tready held low: only FIFO_DEPTH issues, then release
    rdy_mode = 1;
    clr();
    do_start();
    repeat (30) tick();
    chk("stall_issue_cnt", 32'(issue_cnt), 32'(D));
    chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("stall_tuser", 32'(m_axis_tuser), 32'd1);
    chk("stall_tdata", m_axis_tdata, shade(5'd0, 5'd0));
    rdy_mode = 0;
    run_until(FRAME, 1000);
    chk("t2_fd_cnt", 32'(fd_cnt), 32'd1);
    wait_idle();

    // Random tready
    rdy_mode = 2;
    clr();
    do_start();
    run_until(FRAME, 4000);
    chk("t3_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("t3_tlast_cnt", 32'(tlast_cnt), 32'(H));
    rdy_mode = 0;
    wait_idle();

    // Two continuous frames
    rdy_mode = 0;
    clr();
    continuous = 1'b1;
    do_start();
    n = 0;
    while (beat_idx < 2 * FRAME && n < 3000) begin
      tick();
      n++;
      if (beat_idx >= FRAME + 2) continuous = 1'b0;
    end
    chk("t4_beats", 32'(beat_idx), 32'(2 * FRAME));
    chk("t4_fd_cnt", 32'(fd_cnt), 32'd2);
    chk("t4_tuser_cnt", 32'(tuser_cnt), 32'd2);
    chk("t4_gap_bound", 32'(max_gap <= L + 2), 32'd1);
    tick();
    chk("t4_busy_low_next", 32'(busy), 32'd0);

    // Reset mid-frame at beat 150
    rdy_mode = 0;
    clr();
    do_start();
    run_until(151, 500);
    aresetn = 1'b0;
    @(posedge aclk);
    cyc++;
    #1;
    aresetn = 1'b1;
    #1;
    check_zero("midreset");
    clr();
    repeat (6) tick();
    chk("midreset_no_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midreset_no_issue", 32'(issue_cnt), 32'd0);
    do_start();
    run_until(1, 20);
    chk("midreset_first_tuser", 32'(tuser_cnt), 32'd1);
    run_until(FRAME, 1000);
    chk("t5_fd_cnt", 32'(fd_cnt), 32'd1);
    wait_idle();

    // start pulses during ISSUE and DRAIN are ignored
    rdy_mode = 0;
    clr();
    do_start();
    n = 0;
    while (beat_idx < FRAME && n < 1000) begin
      tick();
      n++;
      start = (beat_idx == 50 || beat_idx == FRAME - 2);
    end
    start = 1'b0;
    chk("t6_beats", 32'(beat_idx), 32'(FRAME));
    tick();
    chk("t6_busy_low", 32'(busy), 32'd0);
    repeat (10) tick();
    chk("t6_issue_cnt", 32'(issue_cnt), 32'(FRAME));
    chk("t6_fd_cnt", 32'(fd_cnt), 32'd1);
    chk("t6_still_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
